// File: rtl/wb_sram_ctrl_if.sv
// Wishbone pipelined bus between the GPU local-RAM master and wb_sram_ctrl.
//
// Handshake:
//   A request is presented with WB_CYC_IN & WB_STB_IN. It is taken on the
//   rising clock edge where WB_STALL_OUT is low. Exactly one WB_ACK_OUT or
//   WB_ERR_OUT pulse (one cycle) answers each accepted request. The master
//   must hold WB_CYC_IN high until that pulse arrives. Dropping WB_CYC_IN
//   earlier abandons the access, and no answer is given.
//
// Signals (directions seen from the slave):
//   WB_ADR_IN[31:0]      byte address
//   WB_CYC_IN / WB_STB_IN  cycle / strobe
//   WB_WE_IN             1 = write
//   WB_SEL_IN[3:0]       byte-lane selects
//   WB_CTI_IN / WB_BTE_IN  cycle / burst type (carried, not interpreted)
//   WB_DAT_WR_IN[31:0]   write data
//   WB_STALL_OUT         request cannot be taken this cycle
//   WB_ACK_OUT / WB_ERR_OUT  completion / rejection pulse
//   WB_DAT_RD_OUT[31:0]  read data, valid with WB_ACK_OUT
interface wb_sram_ctrl_if;
  logic [31:0] WB_ADR_IN;
  logic        WB_CYC_IN;
  logic        WB_STB_IN;
  logic        WB_WE_IN;
  logic [3:0]  WB_SEL_IN;
  logic [2:0]  WB_CTI_IN;
  logic [1:0]  WB_BTE_IN;
  logic [31:0] WB_DAT_WR_IN;
  logic        WB_STALL_OUT;
  logic        WB_ACK_OUT;
  logic        WB_ERR_OUT;
  logic [31:0] WB_DAT_RD_OUT;

  modport slave (
    input  WB_ADR_IN, WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_SEL_IN,
           WB_CTI_IN, WB_BTE_IN, WB_DAT_WR_IN,
    output WB_STALL_OUT, WB_ACK_OUT, WB_ERR_OUT, WB_DAT_RD_OUT
  );

  modport master (
    output WB_ADR_IN, WB_CYC_IN, WB_STB_IN, WB_WE_IN, WB_SEL_IN,
           WB_CTI_IN, WB_BTE_IN, WB_DAT_WR_IN,
    input  WB_STALL_OUT, WB_ACK_OUT, WB_ERR_OUT, WB_DAT_RD_OUT
  );
endinterface

// File: rtl/wb_sram_ctrl.sv
// Wishbone pipelined slave bridging the GPU local-RAM bus to an external
// 16-bit asynchronous SRAM. Each 32-bit access becomes one or two 16-bit SRAM
// phases (LO half, then HI half) of WAIT_STATES+1 cycles each, with one
// strobes-off cycle between the two phases. Byte selects map onto LB/UB.
//
// Ports:
//   CLK, RST_ASYNC (async, active low), EN (clock enable, freezes all state)
//   bus            Wishbone slave (see wb_sram_ctrl_if)
//   SRAM_ADDR_OUT  word address; SRAM_DQ_OUT / SRAM_DQ_IN data; SRAM_DQ_OE_OUT
//                  pad enable while writing
//   SRAM_*_N_OUT   active-low chip/output/write enable and byte strobes
//   dbgState       current FSM state (IDLE=0, LO=1, HI=2, DONE=3)
//
// Every output is a flop. The output flops are loaded from the values that
// belong to the state being entered, so the pins line up with the state
// register cycle for cycle.
module wb_sram_ctrl #(
  parameter int SRAM_ADDR_W = 19,
  parameter int WAIT_STATES = 1
) (
  input  logic                   CLK,
  input  logic                   RST_ASYNC,
  input  logic                   EN,
  wb_sram_ctrl_if.slave          bus,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR_OUT,
  output logic [15:0]            SRAM_DQ_OUT,
  input  logic [15:0]            SRAM_DQ_IN,
  output logic                   SRAM_DQ_OE_OUT,
  output logic                   SRAM_CE_N_OUT,
  output logic                   SRAM_OE_N_OUT,
  output logic                   SRAM_WE_N_OUT,
  output logic                   SRAM_LB_N_OUT,
  output logic                   SRAM_UB_N_OUT,
  output logic [1:0]             dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] LAST       = 3'(WAIT_STATES);
  // With wait states the last cycle of a write phase keeps data on the bus
  // with WE_N high; with none, the single cycle is the write pulse.
  localparam bit         HOLD_CYCLE = (WAIT_STATES != 0);

  // FSM and captured request
  state_t                 state, stateNext;
  logic [2:0]             cnt, cntNext;
  logic                   gap, gapNext;        // strobes-off cycle before HI
  logic                   aborted, abortedNext;
  logic                   reqWe, reqWeNext;
  logic                   reqErr, reqErrNext;
  logic [3:0]             reqSel, reqSelNext;
  logic [31:0]            reqDat, reqDatNext;
  logic [SRAM_ADDR_W-2:0] reqWord, reqWordNext;

  // Output registers and their next values
  logic                   stallQ, stallNext;
  logic                   ackQ, ackNext;
  logic                   errQ, errNext;
  logic [31:0]            datRdQ, datRdNext;
  logic [SRAM_ADDR_W-1:0] addrNext;
  logic [15:0]            dqOutNext;
  logic                   dqOeNext, ceNNext, oeNNext, weNNext, lbNNext, ubNNext;

  logic accept;
  logic rangeErr;
  logic phaseEnd;
  logic phaseNext;
  logic hiHalf;
  logic unusedBits;

  assign unusedBits = ^{bus.WB_ADR_IN[1:0], bus.WB_CTI_IN, bus.WB_BTE_IN};

  assign accept   = (state == IDLE) && bus.WB_CYC_IN && bus.WB_STB_IN;
  assign rangeErr = |bus.WB_ADR_IN[31:SRAM_ADDR_W+1];
  // Last cycle of an active SRAM phase (the gap cycle is not a phase)
  assign phaseEnd = ((state == LO) || ((state == HI) && !gap)) && (cnt == LAST);

  // Next-state, capture and output-value logic
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    gapNext     = gap;
    reqWeNext   = reqWe;
    reqErrNext  = reqErr;
    reqSelNext  = reqSel;
    reqDatNext  = reqDat;
    reqWordNext = reqWord;
    // A drop of CYC anywhere in the access is remembered until IDLE.
    abortedNext = (state != IDLE) && (aborted || !bus.WB_CYC_IN);

    case (state)
      IDLE: begin
        if (accept) begin
          reqWeNext   = bus.WB_WE_IN;
          reqErrNext  = rangeErr;
          reqSelNext  = bus.WB_SEL_IN;
          reqDatNext  = bus.WB_DAT_WR_IN;
          reqWordNext = bus.WB_ADR_IN[SRAM_ADDR_W:2];
          cntNext     = 3'd0;
          gapNext     = 1'b0;
          if (rangeErr || (bus.WB_SEL_IN == 4'd0)) begin
            stateNext = DONE;
          end else if (bus.WB_SEL_IN[1:0] != 2'd0) begin
            stateNext = LO;
          end else begin
            stateNext = HI;
          end
        end
      end
      LO: begin
        if (cnt == LAST) begin
          cntNext = 3'd0;
          if ((reqSel[3:2] != 2'd0) && !abortedNext) begin
            stateNext = HI;
            gapNext   = 1'b1;
          end else begin
            stateNext = DONE;
          end
        end else begin
          cntNext = cnt + 3'd1;
        end
      end
      HI: begin
        if (gap) begin
          // The HI phase has not started yet, so an abort skips it entirely.
          gapNext = 1'b0;
          if (abortedNext) begin
            stateNext = DONE;
          end
        end else if (cnt == LAST) begin
          stateNext = DONE;
        end else begin
          cntNext = cnt + 3'd1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Pin values for the cycle that follows this edge
    phaseNext = (stateNext == LO) || ((stateNext == HI) && !gapNext);
    hiHalf    = (stateNext == HI);
    ceNNext   = !phaseNext;
    oeNNext   = !(phaseNext && !reqWeNext);
    weNNext   = !(phaseNext && reqWeNext && !(HOLD_CYCLE && (cntNext == LAST)));
    dqOeNext  = phaseNext && reqWeNext;
    lbNNext   = !(phaseNext && (hiHalf ? reqSelNext[2] : reqSelNext[0]));
    ubNNext   = !(phaseNext && (hiHalf ? reqSelNext[3] : reqSelNext[1]));
    addrNext  = phaseNext ? {reqWordNext, hiHalf} : SRAM_ADDR_OUT;
    dqOutNext = SRAM_DQ_OUT;
    if (phaseNext && reqWeNext) begin
      dqOutNext = hiHalf ? reqDatNext[31:16] : reqDatNext[15:0];
    end

    stallNext = (stateNext != IDLE);
    ackNext   = (state == DONE) && !reqErr && !abortedNext;
    errNext   = (state == DONE) && reqErr && !abortedNext;

    // Read data: cleared on acceptance so unselected bytes read as zero,
    // then each half is sampled on the last cycle of its phase.
    datRdNext = datRdQ;
    if (accept) begin
      datRdNext = 32'd0;
    end else if (phaseEnd && !reqWe) begin
      if (state == LO) begin
        datRdNext[15:0]  = SRAM_DQ_IN & {{8{reqSel[1]}}, {8{reqSel[0]}}};
      end else begin
        datRdNext[31:16] = SRAM_DQ_IN & {{8{reqSel[3]}}, {8{reqSel[2]}}};
      end
    end
  end

  // FSM state and captured request
  always_ff @(posedge CLK or negedge RST_ASYNC) begin
    if (!RST_ASYNC) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      gap     <= 1'b0;
      aborted <= 1'b0;
      reqWe   <= 1'b0;
      reqErr  <= 1'b0;
      reqSel  <= 4'd0;
      reqDat  <= 32'd0;
      reqWord <= '0;
    end else if (EN) begin
      state   <= stateNext;
      cnt     <= cntNext;
      gap     <= gapNext;
      aborted <= abortedNext;
      reqWe   <= reqWeNext;
      reqErr  <= reqErrNext;
      reqSel  <= reqSelNext;
      reqDat  <= reqDatNext;
      reqWord <= reqWordNext;
    end
  end

  // Output registers
  always_ff @(posedge CLK or negedge RST_ASYNC) begin
    if (!RST_ASYNC) begin
      stallQ         <= 1'b0;
      ackQ           <= 1'b0;
      errQ           <= 1'b0;
      datRdQ         <= 32'd0;
      SRAM_ADDR_OUT  <= '0;
      SRAM_DQ_OUT    <= 16'd0;
      SRAM_DQ_OE_OUT <= 1'b0;
      SRAM_CE_N_OUT  <= 1'b1;
      SRAM_OE_N_OUT  <= 1'b1;
      SRAM_WE_N_OUT  <= 1'b1;
      SRAM_LB_N_OUT  <= 1'b1;
      SRAM_UB_N_OUT  <= 1'b1;
    end else if (EN) begin
      stallQ         <= stallNext;
      ackQ           <= ackNext;
      errQ           <= errNext;
      datRdQ         <= datRdNext;
      SRAM_ADDR_OUT  <= addrNext;
      SRAM_DQ_OUT    <= dqOutNext;
      SRAM_DQ_OE_OUT <= dqOeNext;
      SRAM_CE_N_OUT  <= ceNNext;
      SRAM_OE_N_OUT  <= oeNNext;
      SRAM_WE_N_OUT  <= weNNext;
      SRAM_LB_N_OUT  <= lbNNext;
      SRAM_UB_N_OUT  <= ubNNext;
    end
  end

  assign bus.WB_STALL_OUT  = stallQ;
  assign bus.WB_ACK_OUT    = ackQ;
  assign bus.WB_ERR_OUT    = errQ;
  assign bus.WB_DAT_RD_OUT = datRdQ;
  assign dbgState          = state;

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Bench for wb_sram_ctrl: Wishbone driver tasks, an SRAM pin model, a
// byte-array reference memory, and a response monitor fed by an expected
// queue. Each expectation also carries how many cycles CE_N / WE_N / OE_N
// should be seen low for that access.
module tb_wb_sram_ctrl;
  localparam int WS = 1;
  localparam int AW = 19;

  logic          CLK = 1'b0;
  logic          RST_ASYNC = 1'b0;
  logic          EN = 1'b1;
  logic [AW-1:0] sramAddr;
  logic [15:0]   sramDqOut;
  logic [15:0]   sramDqIn;
  logic          sramDqOe, ceN, oeN, weN, lbN, ubN;
  logic [1:0]    dbgState;

  always #5 CLK = ~CLK;

  wb_sram_ctrl_if wb ();

  wb_sram_ctrl #(.SRAM_ADDR_W(AW), .WAIT_STATES(WS)) dut (
    .CLK            (CLK),
    .RST_ASYNC      (RST_ASYNC),
    .EN             (EN),
    .bus            (wb),
    .SRAM_ADDR_OUT  (sramAddr),
    .SRAM_DQ_OUT    (sramDqOut),
    .SRAM_DQ_IN     (sramDqIn),
    .SRAM_DQ_OE_OUT (sramDqOe),
    .SRAM_CE_N_OUT  (ceN),
    .SRAM_OE_N_OUT  (oeN),
    .SRAM_WE_N_OUT  (weN),
    .SRAM_LB_N_OUT  (lbN),
    .SRAM_UB_N_OUT  (ubN),
    .dbgState       (dbgState)
  );

  // SRAM pin model: word array, written mid-cycle while CE_N and WE_N are low.
  logic [15:0] sramMem [4096];
  assign sramDqIn = (!ceN && !oeN) ? sramMem[sramAddr[11:0]] : 16'hFFFF;

  always @(negedge CLK) begin
    if (!ceN && !weN && sramDqOe) begin
      if (!lbN) sramMem[sramAddr[11:0]][7:0]  = sramDqOut[7:0];
      if (!ubN) sramMem[sramAddr[11:0]][15:8] = sramDqOut[15:8];
    end
  end

  // Reference memory: plain byte-addressed array.
  logic [7:0] refMem [8192];

  function automatic void refWrite(input logic [31:0] adr, input logic [3:0] sel,
                                   input logic [31:0] dat);
    for (int i = 0; i < 4; i++)
      if (sel[i]) refMem[{adr[12:2], 2'(i)}] = dat[8*i +: 8];
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] adr, input logic [3:0] sel);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r[8*i +: 8] = refMem[{adr[12:2], 2'(i)}];
    return r;
  endfunction

  // Counters and bookkeeping
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int respCount = 0;
  int ceCnt = 0, weCnt = 0, oeCnt = 0;

  always @(posedge CLK) cycle++;

  always @(negedge CLK) begin
    if (!ceN) ceCnt++;
    if (!weN) weCnt++;
    if (!oeN) oeCnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cycle);
    end
  endtask

  typedef struct packed {
    logic        isErr;
    logic        isRead;
    logic [31:0] data;
    logic [31:0] accCycle;
    logic [31:0] lat;
    logic [31:0] ceStart;
    logic [31:0] weStart;
    logic [31:0] oeStart;
    logic [31:0] ceExp;
    logic [31:0] weExp;
    logic [31:0] oeExp;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;

  // Monitor: every ACK/ERR pulse is matched against the oldest expectation.
  always @(negedge CLK) begin
    if (RST_ASYNC && (wb.WB_ACK_OUT || wb.WB_ERR_OUT)) begin
      respCount++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp ack=%b err=%b with empty queue", wb.WB_ACK_OUT, wb.WB_ERR_OUT);
      end else begin
        cur = expQ.pop_front();
        chk("resp_err", 32'(wb.WB_ERR_OUT), 32'(cur.isErr));
        chk("resp_ack", 32'(wb.WB_ACK_OUT), 32'(!cur.isErr));
        chk("latency", cycle - cur.accCycle, cur.lat);
        if (cur.isRead && !cur.isErr) chk("read_data", wb.WB_DAT_RD_OUT, cur.data);
        chk("ce_low_cycles", ceCnt - cur.ceStart, cur.ceExp);
        chk("we_low_cycles", weCnt - cur.weStart, cur.weExp);
        chk("oe_low_cycles", oeCnt - cur.oeStart, cur.oeExp);
      end
    end
  end

  task automatic idleBus();
    wb.WB_CYC_IN    = 1'b0;
    wb.WB_STB_IN    = 1'b0;
    wb.WB_WE_IN     = 1'b0;
    wb.WB_SEL_IN    = 4'd0;
    wb.WB_ADR_IN    = 32'd0;
    wb.WB_DAT_WR_IN = 32'd0;
    wb.WB_CTI_IN    = 3'd0;
    wb.WB_BTE_IN    = 2'd0;
  endtask

  // One Wishbone access. dropCyc abandons it one cycle after acceptance;
  // freeze holds EN low for that many cycles right after acceptance.
  task automatic doAccess(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, input bit dropCyc, input int freeze);
    exp_t e;
    int n, phases, active, startResp;
    bit inRange;
    @(negedge CLK);
    wb.WB_CYC_IN    = 1'b1;
    wb.WB_STB_IN    = 1'b1;
    wb.WB_ADR_IN    = adr;
    wb.WB_WE_IN     = we;
    wb.WB_SEL_IN    = sel;
    wb.WB_DAT_WR_IN = dat;
    wb.WB_CTI_IN    = 3'($urandom_range(0, 7));
    wb.WB_BTE_IN    = 2'($urandom_range(0, 3));
    n = 0;
    while (wb.WB_STALL_OUT && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("stall_wait_timeout", 32'(n < 20), 32'd1);
    @(posedge CLK);
    #1;
    wb.WB_STB_IN = 1'b0;
    startResp = respCount;

    inRange = ((adr >> (AW + 1)) == 0);
    phases  = int'(sel[1:0] != 2'd0) + int'(sel[3:2] != 2'd0);
    active  = inRange ? phases : 0;
    e.isErr    = !inRange;
    e.isRead   = !we;
    e.data     = refRead(adr, sel);
    e.accCycle = cycle;
    if (!inRange || sel == 4'd0) e.lat = 1;
    else if (phases == 2)       e.lat = 2 * (WS + 1) + 2 + freeze;
    else                        e.lat = (WS + 1) + 1 + freeze;
    e.ceStart = ceCnt;
    e.weStart = weCnt;
    e.oeStart = oeCnt;
    e.ceExp   = active * (WS + 1) + ((active != 0) ? freeze : 0);
    e.oeExp   = we ? 0 : e.ceExp;
    e.weExp   = we ? active * ((WS == 0) ? 1 : WS) : 0;

    if (dropCyc) begin
      if (we && inRange) refWrite(adr, {2'b00, sel[1:0]}, dat);
    end else begin
      if (we && inRange) refWrite(adr, sel, dat);
      expQ.push_back(e);
    end

    @(negedge CLK);
    chk("stall_after_accept", 32'(wb.WB_STALL_OUT), 32'd1);

    if (dropCyc) begin
      wb.WB_CYC_IN = 1'b0;
      repeat (10) @(negedge CLK);
      chk("abort_ce_cycles", ceCnt - e.ceStart, 32'(WS + 1));
      chk("abort_no_resp", respCount - startResp, 32'd0);
      chk("abort_stall_clear", 32'(wb.WB_STALL_OUT), 32'd0);
    end else begin
      if (freeze > 0) begin
        EN = 1'b0;
        repeat (freeze) @(negedge CLK);
        EN = 1'b1;
      end
      n = 0;
      while (respCount == startResp && n < 40) begin
        @(negedge CLK);
        n++;
      end
      chk("resp_timeout", 32'(respCount != startResp), 32'd1);
      wb.WB_CYC_IN = 1'b0;
    end
  endtask

  initial begin
    int n;
    logic [31:0] adr;
    for (int i = 0; i < 4096; i++) sramMem[i] = 16'd0;
    for (int i = 0; i < 8192; i++) refMem[i] = 8'd0;
    idleBus();

    // Outputs while reset is held
    #12;
    chk("rst_stall_ack_err", {29'd0, wb.WB_STALL_OUT, wb.WB_ACK_OUT, wb.WB_ERR_OUT}, 32'd0);
    chk("rst_dat_rd", wb.WB_DAT_RD_OUT, 32'd0);
    chk("rst_strobes_n", {27'd0, ceN, oeN, weN, lbN, ubN}, 32'h1F);
    chk("rst_dq_oe", 32'(sramDqOe), 32'd0);
    chk("rst_addr", 32'(sramAddr), 32'd0);
    chk("rst_dq_out", 32'(sramDqOut), 32'd0);
    @(negedge CLK);
    RST_ASYNC = 1'b1;
    repeat (2) @(negedge CLK);

    // Directed accesses
    doAccess(32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 0);
    chk("sram_word8", 32'(sramMem[8]), 32'h0000_BEEF);
    chk("sram_word9", 32'(sramMem[9]), 32'h0000_DEAD);
    doAccess(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 0);
    doAccess(32'h0000_0010, 1'b1, 4'b0100, 32'h00AB_0000, 1'b0, 0);
    chk("sram_word9_byte", 32'(sramMem[9]), 32'h0000_DEAB);
    doAccess(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 0);
    doAccess(32'h0010_0000, 1'b1, 4'hF, 32'h1111_2222, 1'b0, 0);
    doAccess(32'h0000_0020, 1'b1, 4'hF, 32'h1234_5678, 1'b1, 0);
    doAccess(32'h0000_0020, 1'b0, 4'hF, 32'h0, 1'b0, 0);
    doAccess(32'h0000_0010, 1'b0, 4'h0, 32'h0, 1'b0, 0);
    doAccess(32'h0000_0010, 1'b0, 4'b0011, 32'h0, 1'b0, 0);

    // Reset in the HI phase of a read
    @(negedge CLK);
    wb.WB_CYC_IN = 1'b1;
    wb.WB_STB_IN = 1'b1;
    wb.WB_WE_IN  = 1'b0;
    wb.WB_SEL_IN = 4'hF;
    wb.WB_ADR_IN = 32'h0000_0010;
    @(posedge CLK);
    #1;
    wb.WB_STB_IN = 1'b0;
    n = 0;
    while (!(sramAddr[0] && !ceN) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("hi_phase_seen", 32'(n < 20), 32'd1);
    #2;
    RST_ASYNC = 1'b0;
    #1;
    chk("midrst_strobes_n", {27'd0, ceN, oeN, weN, lbN, ubN}, 32'h1F);
    chk("midrst_stall_ack", {30'd0, wb.WB_STALL_OUT, wb.WB_ACK_OUT}, 32'd0);
    chk("midrst_dat_rd", wb.WB_DAT_RD_OUT, 32'd0);
    @(negedge CLK);
    wb.WB_CYC_IN = 1'b0;
    @(negedge CLK);
    RST_ASYNC = 1'b1;
    @(negedge CLK);
    chk("postrst_stall", 32'(wb.WB_STALL_OUT), 32'd0);
    doAccess(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 0);

    // Clock-enable freeze during a read
    doAccess(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 3);

    // Randomized traffic over a small window so addresses collide
    for (int k = 0; k < 60; k++) begin
      adr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) adr = adr | (32'd1 << $urandom_range(AW + 1, 31));
      doAccess(adr, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b0, 0);
    end

    repeat (5) @(negedge CLK);
    chk("queue_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_sram_ctrl.md
Name: wb_sram_ctrl

Overview:
Wishbone pipelined slave that bridges the GPU local-RAM bus (WB_GPU_* from PSX_TOP) to an external 16-bit asynchronous SRAM. It occupies the slot the ideal GPU RAM model fills in simulation, so the design can run on an FPGA board.
Each 32-bit Wishbone access becomes one or two 16-bit SRAM phases with programmable wait states. Byte lanes map to the SRAM LB/UB strobes.

Parameters:
SRAM_ADDR_W, 19, SRAM word-address width; 2^19 x 16 bits = 1MB window.
WAIT_STATES, 1, extra cycles per SRAM phase; each phase lasts WAIT_STATES+1 cycles; legal range 0..7.

Ports:
CLK  in  1  system clock
RST_ASYNC  in  1  asynchronous, active-low reset
EN  in  1  clock enable; when low, all state holds
WB_ADR_IN  in  32  byte address
WB_CYC_IN  in  1  bus cycle
WB_STB_IN  in  1  strobe
WB_WE_IN  in  1  write enable
WB_SEL_IN  in  4  byte-lane selects
WB_CTI_IN  in  3  cycle type; accepted but ignored, every access is single
WB_BTE_IN  in  2  burst type; ignored
WB_STALL_OUT  out  1  request not accepted this cycle
WB_ACK_OUT  out  1  access complete
WB_ERR_OUT  out  1  access rejected
WB_DAT_RD_OUT  out  32  read data
WB_DAT_WR_IN  in  32  write data
SRAM_ADDR_OUT  out  SRAM_ADDR_W  word address
SRAM_DQ_OUT  out  16  write data
SRAM_DQ_IN  in  16  read data
SRAM_DQ_OE_OUT  out  1  pad output enable; high while driving writes
SRAM_CE_N_OUT, SRAM_OE_N_OUT, SRAM_WE_N_OUT, SRAM_LB_N_OUT, SRAM_UB_N_OUT  out  1 each  active-low SRAM strobes

Behaviour:
- Reset (RST_ASYNC=0), effective immediately:
  - STALL=0, ACK=0, ERR=0, DAT_RD=0.
  - All SRAM_*_N=1, DQ_OE=0, ADDR=0, DQ_OUT=0.
  - FSM returns to IDLE; an access in flight is abandoned with no ACK.
- FSM states: IDLE, LO, HI, DONE. All outputs are registered.
- STALL=1 in every state except IDLE.
- Request acceptance (IDLE with CYC&STB):
  - Capture ADR, WE, SEL and DAT_WR.
  - If ADR[31:SRAM_ADDR_W+1] is nonzero: go to DONE and assert ERR, not ACK. No SRAM activity.
  - If SEL=0: go to DONE and assert ACK. No SRAM activity; DAT_RD=0 for a read.
  - Otherwise go to LO if SEL[1:0]!=0, else HI.
- LO phase:
  - ADDR={ADR[SRAM_ADDR_W:2],1'b0}.
  - LB_N=~SEL[0], UB_N=~SEL[1].
  - Next state is HI if SEL[3:2]!=0, else DONE.
- HI phase:
  - ADDR={ADR[SRAM_ADDR_W:2],1'b1}.
  - LB_N=~SEL[2], UB_N=~SEL[3].
  - Next state is DONE.
- Phase timing: each phase lasts WAIT_STATES+1 cycles, counted by a 3-bit counter. CE_N=0 for the whole phase.
- Read phase:
  - OE_N=0 for the whole phase.
  - DQ_IN is sampled on the last cycle of the phase into DAT_RD[15:0] (LO) or DAT_RD[31:16] (HI).
  - Unselected bytes read as 0.
- Write phase:
  - DQ_OE=1 and DQ_OUT = the selected half for the whole phase.
  - WE_N=0 on every cycle of the phase except the last, which is a data-hold cycle.
  - When WAIT_STATES=0, WE_N=0 for the single cycle.
- Strobes return high for at least 1 cycle between LO and HI.
- DONE: ACK (or ERR) is high for exactly 1 cycle, then the FSM returns to IDLE. The earliest next acceptance is the cycle after DONE.
- Latency, counted from the acceptance edge to ACK high, with WAIT_STATES=1:
  - 2-phase access: 6 cycles.
  - 1-phase access: 3 cycles.
  - ERR or SEL=0: 1 cycle.
- CYC dropped mid-access: the current SRAM phase completes, so no truncated write occurs. The remaining phase is skipped and ACK is suppressed.
- EN=0 freezes the FSM, the counter and all outputs.

Test Plan:
- Reset, then 32-bit write: ADR=0x0000_0010, SEL=F, DAT=0xDEAD_BEEF, WAIT_STATES=1 -> STALL high on the cycle after acceptance. LO phase writes 0xBEEF to word 8, HI phase writes 0xDEAD to word 9. Each phase has WE_N low 1 cycle then high 1 cycle. ACK pulses 6 cycles after acceptance.
- Read back the same address with the SRAM model -> DAT_RD=0xDEAD_BEEF in the ACK cycle; OE_N low through both phases, WE_N held high.
- Byte write: SEL=4'b0100, DAT=0x00AB_0000 -> HI phase only, LB_N=0 and UB_N=1, DQ_OUT=0x00AB. ACK 3 cycles after acceptance. Other SRAM bytes unchanged.
- Out-of-range access: ADR=0x0010_0000 -> ERR for 1 cycle, 1 cycle after acceptance. No ACK; CE_N stays high throughout.
- Drop CYC during the LO phase of a full write -> LO phase completes, HI phase never starts, no ACK. The next request is accepted normally.
- Assert RST_ASYNC low during HI of a read -> all strobes deassert immediately, no ACK. After release, STALL=0 and a new read completes correctly.
